// File: rtl/mealy_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_seq_detector
//  Description : Programmable-pattern Mealy sequence detector on a qualified
//                serial bit stream, with overlapping / non-overlapping
//                detection and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mealy_seq_detector #(
    parameter int LEN   = 4,    // pattern length, 2..16
    parameter int CNT_W = 8     // match counter width
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     w,
    input  logic                     en,
    input  logic                     cfg_load,
    input  logic [LEN-1:0]           cfg_pattern,
    input  logic                     cfg_overlap,
    input  logic                     clr_count,
    output logic                     z,
    output logic [CNT_W-1:0]         match_count,
    output logic [$clog2(LEN)-1:0]   fill,
    output logic                     armed
);

    localparam int FILL_W = $clog2(LEN);
    localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(LEN - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LEN-1:0]      pat_q,   pat_d;
    logic                ovl_q,   ovl_d;
    logic [LEN-2:0]      hist_q,  hist_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                armed_q, armed_d;

    // History with the current bit appended; bit 0 is the newest sample.
    logic [LEN-1:0]      w_window;
    logic                w_accept;
    logic                w_match;

    // Match decode: a full history plus the live bit equal to the pattern.
    always_comb begin
        w_window = {hist_q, w};
        w_accept = (state_q == ST_RUN) && en && !cfg_load;
        w_match  = w_accept && (fill_q == C_FILL_MAX) && (w_window == pat_q);
    end

    // Next-state: configuration load dominates sample acceptance.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        armed_d = armed_q;
        count_d = count_q;

        if (cfg_load) begin
            state_d = ST_RUN;
            pat_d   = cfg_pattern;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            armed_d = 1'b1;
        end else if (w_accept) begin
            hist_d = w_window[LEN-2:0];
            if (w_match) begin
                // Non-overlapping restarts the fill so LEN fresh bits are needed.
                fill_d = ovl_q ? C_FILL_MAX : '0;
            end else if (fill_q != C_FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // Clear wins over a same-cycle increment.
        if (clr_count) begin
            count_d = '0;
        end else if (w_match && (count_q != C_CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_UNCFG;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    assign z           = w_match;
    assign match_count = count_q;
    assign fill        = fill_q;
    assign armed       = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mealy_seq_detector
//  Description : Directed self-checking bench for mealy_seq_detector
//                (LEN=4/CNT_W=8 instance and LEN=2/CNT_W=2 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_seq_detector;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;

    // Instance A: LEN=4, CNT_W=8
    logic       w_a = 1'b0, en_a = 1'b0, ld_a = 1'b0, clr_a = 1'b0, ovl_a = 1'b0;
    logic [3:0] pat_a = 4'b0000;
    logic       z_a;
    logic [7:0] cnt_a;
    logic [1:0] fill_a;
    logic       armed_a;

    // Instance B: LEN=2, CNT_W=2
    logic       w_b = 1'b0, en_b = 1'b0, ld_b = 1'b0, clr_b = 1'b0, ovl_b = 1'b0;
    logic [1:0] pat_b = 2'b00;
    logic       z_b;
    logic [1:0] cnt_b;
    logic [0:0] fill_b;
    logic       armed_b;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    mealy_seq_detector #(.LEN(4), .CNT_W(8)) u_dut_a (
        .Clock       (Clock),
        .Reset       (Reset),
        .w           (w_a),
        .en          (en_a),
        .cfg_load    (ld_a),
        .cfg_pattern (pat_a),
        .cfg_overlap (ovl_a),
        .clr_count   (clr_a),
        .z           (z_a),
        .match_count (cnt_a),
        .fill        (fill_a),
        .armed       (armed_a)
    );

    mealy_seq_detector #(.LEN(2), .CNT_W(2)) u_dut_b (
        .Clock       (Clock),
        .Reset       (Reset),
        .w           (w_b),
        .en          (en_b),
        .cfg_load    (ld_b),
        .cfg_pattern (pat_b),
        .cfg_overlap (ovl_b),
        .clr_count   (clr_b),
        .z           (z_b),
        .match_count (cnt_b),
        .fill        (fill_b),
        .armed       (armed_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on instance A: drive after negedge, check z before posedge.
    task automatic cyc_a(input logic wi, input logic ei, input logic li,
                         input logic ci, input logic exp_z, input string tag);
        @(negedge Clock);
        w_a = wi; en_a = ei; ld_a = li; clr_a = ci;
        #1;
        chk(tag, {31'd0, z_a}, {31'd0, exp_z});
    endtask

    task automatic cyc_b(input logic wi, input logic ei, input logic li,
                         input logic ci, input logic exp_z, input string tag);
        @(negedge Clock);
        w_b = wi; en_b = ei; ld_b = li; clr_b = ci;
        #1;
        chk(tag, {31'd0, z_b}, {31'd0, exp_z});
    endtask

    // Wait past the next rising edge so registered outputs can be checked.
    task automatic settle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [6:0] stream;
        logic [6:0] expz;

        // ---------------- reset state ----------------
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_z",     {31'd0, z_a},     32'd0);
        chk("rst_count", {24'd0, cnt_a},   32'd0);
        chk("rst_fill",  {30'd0, fill_a},  32'd0);
        chk("rst_armed", {31'd0, armed_a}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // ---------------- no cfg_load: never matches ----------------
        for (int i = 0; i < 8; i++) begin
            stream = 7'b1011011;
            cyc_a(((i % 4) == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "uncfg_z");
        end
        settle();
        chk("uncfg_armed", {31'd0, armed_a}, 32'd0);
        chk("uncfg_count", {24'd0, cnt_a},   32'd0);
        chk("uncfg_fill",  {30'd0, fill_a},  32'd0);

        // ---------------- overlapping, pattern 1011 ----------------
        pat_a = 4'b1011; ovl_a = 1'b1;
        cyc_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "ovl_load_z");
        settle();
        chk("ovl_load_armed", {31'd0, armed_a}, 32'd1);
        chk("ovl_load_fill",  {30'd0, fill_a},  32'd0);
        stream = 7'b1011011;
        expz   = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            cyc_a(stream[i], 1'b1, 1'b0, 1'b0, expz[i], "ovl_z");
        end
        settle();
        chk("ovl_count", {24'd0, cnt_a},  32'd2);
        chk("ovl_fill",  {30'd0, fill_a}, 32'd3);

        // ---------------- non-overlapping, counter cleared at load ----------------
        ovl_a = 1'b0;
        cyc_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "novl_load_z");
        settle();
        chk("novl_load_count", {24'd0, cnt_a}, 32'd0);
        expz = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            cyc_a(stream[i], 1'b1, 1'b0, 1'b0, expz[i], "novl_z");
        end
        settle();
        chk("novl_count", {24'd0, cnt_a},  32'd1);
        chk("novl_fill",  {30'd0, fill_a}, 32'd3);

        // ---------------- load leaves the counter untouched ----------------
        ovl_a = 1'b1;
        cyc_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "gap_load_z");
        settle();
        chk("load_keeps_count", {24'd0, cnt_a}, 32'd1);

        // ---------------- en gaps of 3 between qualified bits ----------------
        stream = 7'b0001011;
        for (int i = 3; i >= 0; i--) begin
            cyc_a(stream[i], 1'b1, 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0, "gap_bit_z");
            if (i != 0) begin
                for (int g = 0; g < 3; g++) begin
                    cyc_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap_idle_z");
                end
                settle();
                chk("gap_fill_hold", {30'd0, fill_a}, 32'(4 - i));
            end
        end
        settle();
        chk("gap_count", {24'd0, cnt_a}, 32'd2);

        // ---------------- cfg_load mid-stream discards history ----------------
        cyc_a(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid_load0_z");
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_b1_z");
        cyc_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mid_b2_z");
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_b3_z");
        cyc_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "mid_reload_z");
        settle();
        chk("mid_reload_fill", {30'd0, fill_a}, 32'd0);
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_next_z");
        settle();
        chk("mid_next_fill", {30'd0, fill_a}, 32'd1);

        // ---------------- reset mid-stream ----------------
        cyc_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst_z");
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst_z2");
        @(negedge Clock);
        Reset = 1'b1; w_a = 1'b0;
        settle();
        chk("mid_rst_z",     {31'd0, z_a},     32'd0);
        chk("mid_rst_count", {24'd0, cnt_a},   32'd0);
        chk("mid_rst_fill",  {30'd0, fill_a},  32'd0);
        chk("mid_rst_armed", {31'd0, armed_a}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cyc_a(stream[i], 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_z");
        end

        // ---------------- LEN=2, CNT_W=2: saturation and clear ----------------
        pat_b = 2'b11; ovl_b = 1'b1;
        cyc_b(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "sat_load_z");
        for (int i = 1; i <= 6; i++) begin
            cyc_b(1'b1, 1'b1, 1'b0, 1'b0, (i >= 2) ? 1'b1 : 1'b0, "sat_z");
        end
        settle();
        chk("sat_count", {30'd0, cnt_b},  32'd3);
        chk("sat_fill",  {31'd0, fill_b}, 32'd1);
        cyc_b(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clr_match_z");
        settle();
        chk("clr_count", {30'd0, cnt_b}, 32'd0);
        cyc_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "after_clr_z");
        settle();
        chk("after_clr_count", {30'd0, cnt_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
